// File: rtl/softmax_result_unloader.sv
// softmax_result_unloader: reads finished softmax result vectors from the shared result BRAM
// (port B) and streams them to the host consumer over valid/ready. Each case tags its last word.
module softmax_result_unloader #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned BASE_ADDR = 1024,
  parameter int unsigned VEC_LEN   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              start,
  input  logic [7:0]        case_num,
  output logic [ADDR_W-1:0] addrb,
  output logic              enb,
  input  logic [DATA_W-1:0] dout_b,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CntW = 12;
  localparam int unsigned IdxW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CntW-1:0]   total_q, total_d;
  logic [CntW-1:0]   issued_q, issued_d;
  logic [CntW-1:0]   accepted_q, accepted_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [IdxW-1:0]   widx_q, widx_d;
  logic              prime_q, prime_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Read pipeline: data for a read issued last cycle is on dout_b this cycle.
  logic              rd_vld_q, rd_vld_d;
  logic              rd_last_q, rd_last_d;

  // Two-entry output skid buffer; entry 0 is the head.
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] buf0_q, buf0_d;
  logic [DATA_W-1:0] buf1_q, buf1_d;
  logic              last0_q, last0_d;
  logic              last1_q, last1_d;

  logic pop;
  logic push;
  logic credit_ok;
  logic issue;
  logic last_word;

  assign pop       = en && (cnt_q != 2'd0) && m_ready;
  assign push      = en && rd_vld_q;
  // Words already buffered plus the one on dout_b, less the one leaving now, must leave room.
  assign credit_ok = ({1'b0, cnt_q} + {2'b00, rd_vld_q}) < (3'd2 + {2'b00, pop});
  // prime_q holds off the first read one cycle, giving the 3-cycle start-to-valid latency.
  assign issue     = en && (state_q == StRun) && !prime_q && (issued_q < total_q) && credit_ok;
  assign last_word = (widx_q == IdxW'(VEC_LEN - 1));

  assign addrb   = addr_q;
  assign enb     = issue;
  assign m_data  = buf0_q;
  assign m_valid = (cnt_q != 2'd0);
  assign m_last  = last0_q;
  assign busy    = busy_q;
  assign done    = done_q;

  // Control FSM: start handling, read issue counting and completion.
  always_comb begin
    state_d    = state_q;
    total_d    = total_q;
    issued_d   = issued_q;
    accepted_d = accepted_q;
    addr_d     = addr_q;
    widx_d     = widx_q;
    prime_d    = prime_q;
    busy_d     = busy_q;
    done_d     = done_q;
    if (en) begin
      if (pop) begin
        accepted_d = accepted_q + CntW'(1);
      end
      case (state_q)
        StIdle: begin
          if (start) begin
            total_d    = CntW'(case_num) * CntW'(VEC_LEN);
            addr_d     = ADDR_W'(BASE_ADDR);
            issued_d   = '0;
            accepted_d = '0;
            widx_d     = '0;
            if (case_num == 8'd0) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else begin
              state_d = StRun;
              busy_d  = 1'b1;
              prime_d = 1'b1;
            end
          end
        end
        StRun: begin
          prime_d = 1'b0;
          if (issue) begin
            addr_d   = addr_q + ADDR_W'(1);
            issued_d = issued_q + CntW'(1);
            widx_d   = last_word ? '0 : widx_q + IdxW'(1);
            if (issued_q + CntW'(1) == total_q) begin
              state_d = StDrain;
            end
          end
        end
        StDrain: begin
          if (pop && (accepted_q + CntW'(1) == total_q)) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
        StDone: begin
          done_d  = 1'b0;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Read pipeline and skid buffer: capture dout_b the cycle after issue, pop on handshake.
  always_comb begin
    rd_vld_d  = en ? issue : rd_vld_q;
    rd_last_d = issue ? last_word : rd_last_q;
    cnt_d     = cnt_q;
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    last0_d   = last0_q;
    last1_d   = last1_q;
    case (cnt_q)
      2'd0: begin
        if (push) begin
          buf0_d  = dout_b;
          last0_d = rd_last_q;
          cnt_d   = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          buf0_d  = dout_b;
          last0_d = rd_last_q;
        end else if (push) begin
          buf1_d  = dout_b;
          last1_d = rd_last_q;
          cnt_d   = 2'd2;
        end else if (pop) begin
          cnt_d = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          buf0_d  = buf1_q;
          last0_d = last1_q;
          if (push) begin
            buf1_d  = dout_b;
            last1_d = rd_last_q;
          end else begin
            cnt_d = 2'd1;
          end
        end
      end
      default: cnt_d = 2'd0;
    endcase
  end

  // State registers with synchronous active-low reset; reset drops any in-flight read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      total_q    <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      addr_q     <= ADDR_W'(BASE_ADDR);
      widx_q     <= '0;
      prime_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_last_q  <= 1'b0;
      cnt_q      <= 2'd0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      last0_q    <= 1'b0;
      last1_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      issued_q   <= issued_d;
      accepted_q <= accepted_d;
      addr_q     <= addr_d;
      widx_q     <= widx_d;
      prime_q    <= prime_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_vld_q   <= rd_vld_d;
      rd_last_q  <= rd_last_d;
      cnt_q      <= cnt_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      last0_q    <= last0_d;
      last1_q    <= last1_d;
    end
  end

endmodule

// File: tb/tb_softmax_result_unloader.sv
// Bench for softmax_result_unloader: a BRAM whose word equals its address, a queue-based
// model of the expected beat stream, and a per-cycle compare process.
module tb_softmax_result_unloader;

  localparam int BASE = 1024;
  localparam int VLEN = 16;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        start;
  logic [7:0]  case_num;
  logic [11:0] addrb;
  logic        enb;
  logic [63:0] dout_b;
  logic [63:0] m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready;
  logic        busy;
  logic        done;

  softmax_result_unloader #(
    .ADDR_W   (12),
    .DATA_W   (64),
    .BASE_ADDR(1024),
    .VEC_LEN  (16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .start   (start),
    .case_num(case_num),
    .addrb   (addrb),
    .enb     (enb),
    .dout_b  (dout_b),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_last  (m_last),
    .m_ready (m_ready),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: every word holds its own address; output holds when enb is low.
  initial dout_b = '0;
  always @(posedge clk) if (enb) dout_b <= 64'(addrb);

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference model state
  logic [63:0] exp_data[$];
  bit          exp_last[$];
  bit          active      = 0;
  bit          done_exp    = 0;
  int          run_total   = 0;
  int          run_issued  = 0;
  int          run_acc     = 0;
  int          start_cyc   = 0;
  bit          seen_valid  = 0;
  bit          prev_rst_low = 0;
  bit          prev_en_low  = 0;
  bit          prev_stall   = 0;
  logic [11:0] snap_addr;
  logic [63:0] snap_data;
  logic        snap_valid, snap_last, snap_busy, snap_done;

  // Per-run statistics
  int          beats, lasts, enbs, valids, dones;
  int          first_lat, first_cyc, last_cyc;
  logic [63:0] first_data;

  int          rdy_mode = 0;
  bit          rand_en  = 0;

  // Compare process: outputs checked every cycle against the model, then model advanced.
  always @(negedge clk) begin
    logic hs, final_hs, acc_start;
    logic [63:0] d0;
    bit l0;
    hs = 1'b0;
    final_hs = 1'b0;
    if (prev_rst_low) begin
      check("rst_addrb", addrb, 64'(BASE));
      check("rst_enb", enb, 0);
      check("rst_m_data", m_data, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_last", m_last, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
    end else if (rst_n) begin
      if (prev_en_low) begin
        check("frz_addrb", addrb, snap_addr);
        check("frz_m_valid", m_valid, snap_valid);
        check("frz_m_data", m_data, snap_data);
        check("frz_busy", busy, snap_busy);
        check("frz_done", done, snap_done);
      end
      if (prev_stall) begin
        check("stall_m_valid", m_valid, 1);
        check("stall_m_data", m_data, snap_data);
        check("stall_m_last", m_last, snap_last);
      end
      check("done", done, done_exp);
      check("busy", busy, active);
      if (!active) check("idle_m_valid", m_valid, 0);
      else check("outstanding_le2", (run_issued - run_acc) <= 2, 1);
      if (done) dones++;
      if (m_valid) valids++;
      if (m_valid && active && !seen_valid) begin
        seen_valid = 1;
        first_lat  = int'(cyc) - start_cyc;
        first_cyc  = int'(cyc);
      end
      if (enb && en) begin
        check("enb_while_active", active, 1);
        check("enb_within_total", run_issued < run_total, 1);
        check("addrb", addrb, 64'(12'(BASE + run_issued)));
        run_issued++;
        enbs++;
      end
      hs = en && m_valid && m_ready;
      if (hs) begin
        if (exp_data.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_beat: got data %0h, no beat expected", m_data);
        end else begin
          check("beat_data", m_data, exp_data[0]);
          check("beat_last", m_last, 64'(exp_last[0]));
          d0 = exp_data.pop_front();
          l0 = exp_last.pop_front();
          if (beats == 0) first_data = m_data;
          beats++;
          if (m_last) lasts++;
          last_cyc = int'(cyc);
          run_acc++;
          final_hs = active && (exp_data.size() == 0);
        end
      end
    end
    if (!rst_n) begin
      exp_data.delete();
      exp_last.delete();
      active     = 0;
      done_exp   = 0;
      run_issued = 0;
      run_acc    = 0;
    end else if (en) begin
      acc_start = start && !active && !done_exp;
      done_exp  = final_hs;
      if (final_hs) active = 0;
      if (acc_start) begin
        run_total  = int'(case_num) * VLEN;
        run_issued = 0;
        run_acc    = 0;
        start_cyc  = int'(cyc) + 1;
        seen_valid = 0;
        if (case_num == 8'd0) begin
          done_exp = 1;
        end else begin
          active = 1;
          for (int i = 0; i < run_total; i++) begin
            exp_data.push_back(64'(BASE + i));
            exp_last.push_back((i % VLEN) == VLEN - 1);
          end
        end
      end
    end
    prev_rst_low = !rst_n;
    prev_en_low  = rst_n && !en;
    prev_stall   = rst_n && en && m_valid && !m_ready;
    snap_addr    = addrb;
    snap_data    = m_data;
    snap_valid   = m_valid;
    snap_last    = m_last;
    snap_busy    = busy;
    snap_done    = done;
  end

  // Consumer ready / enable driver
  initial begin
    int pat;
    pat = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: begin
          m_ready = (pat == 0);
          pat = (pat + 1) % 3;
        end
        2: m_ready = ($urandom_range(0, 3) != 0);
        default: m_ready = 1'b1;
      endcase
      if (rand_en) en = ($urandom_range(0, 5) != 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    beats = 0; lasts = 0; enbs = 0; valids = 0; dones = 0;
    first_lat = -1; first_cyc = 0; last_cyc = 0; first_data = '0;
  endtask

  task automatic drive_start(input logic [7:0] n);
    start    = 1'b1;
    case_num = n;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int d0;
    d0 = dones;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (dones != d0) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL %s_timeout: no done within %0d cycles", nm, budget);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; start = 1'b0; case_num = 8'd0; m_ready = 1'b1;
    clear_stats();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("init_addrb", addrb, 64'd1024);
    check("init_busy", busy, 0);
    check("init_m_valid", m_valid, 0);

    // Two cases, m_ready always high
    rdy_mode = 0;
    clear_stats();
    drive_start(8'd2);
    wait_done(400, "t1");
    check("t1_beats", beats, 32);
    check("t1_lasts", lasts, 2);
    check("t1_first_latency", 64'(first_lat), 3);
    check("t1_back_to_back_span", 64'(last_cyc - first_cyc), 31);
    check("t1_enb_count", enbs, 32);
    check("t1_queue_empty", exp_data.size(), 0);
    tick();
    check("t1_busy_after", busy, 0);

    // One case with ready pattern 1,0,0
    rdy_mode = 1;
    clear_stats();
    drive_start(8'd1);
    wait_done(400, "t2");
    check("t2_beats", beats, 16);
    check("t2_lasts", lasts, 1);
    check("t2_enb_count", enbs, 16);
    check("t2_queue_empty", exp_data.size(), 0);

    // Zero cases
    rdy_mode = 0;
    tick();
    clear_stats();
    drive_start(8'd0);
    wait_done(10, "t3");
    tick();
    check("t3_enb_count", enbs, 0);
    check("t3_valid_count", valids, 0);
    check("t3_done_count", dones, 1);

    // Second start and case_num change mid-transfer are ignored
    clear_stats();
    drive_start(8'd1);
    repeat (4) tick();
    case_num = 8'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(400, "t4");
    check("t4_beats", beats, 16);
    check("t4_enb_count", enbs, 16);
    tick();

    // en low for 4 cycles mid-stream
    clear_stats();
    drive_start(8'd1);
    repeat (5) tick();
    en = 1'b0;
    repeat (4) tick();
    en = 1'b1;
    wait_done(400, "t5");
    check("t5_beats", beats, 16);
    check("t5_span_with_freeze", 64'(last_cyc - first_cyc), 19);
    check("t5_enb_count", enbs, 16);
    tick();

    // Reset at beat 7, then restart
    clear_stats();
    drive_start(8'd1);
    for (int i = 0; i < 200 && beats < 7; i++) tick();
    check("t6_reached_beat7", beats, 7);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6_m_valid", m_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_addrb", addrb, 64'd1024);
    check("t6_m_data", m_data, 0);
    check("t6_enb", enb, 0);
    tick();
    clear_stats();
    drive_start(8'd1);
    wait_done(400, "t6");
    check("t6_first_data", first_data, 64'd1024);
    check("t6_beats", beats, 16);

    // Randomised ready and enable
    rdy_mode = 2;
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 3);
      rand_en = 0;
      en = 1'b1;
      tick();
      tick();
      clear_stats();
      drive_start(8'(n));
      rand_en = 1;
      wait_done(3000, "rand");
      rand_en = 0;
      en = 1'b1;
      check("rand_beats", beats, 64'(n * 16));
      check("rand_lasts", lasts, 64'(n));
      check("rand_queue_empty", exp_data.size(), 0);
    end

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
